mips_pc_next: RTL and testbench

- Next-PC selection unit for the single-cycle MIPS CPU.
- Combinationally computes the address of the next instruction from the current PC, the decoded control flags, the branch offset, the jump field, the jr register value and the CP0 target.
- The PC register itself lives in the datapath and loads next_pc each rising clock edge.
- The unit also captures the faulting PC for CP0 when an exception is raised.

---
 rtl/mips_pc_next.sv | 51 +++++
 tb/tb_mips_pc_next.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mips_pc_next.sv
// Next-PC selection for the single-cycle MIPS core, plus the exception PC
// capture register handed to CP0.
module mips_pc_next #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] present_pc,
  input  logic [31:0] extend_inst,
  input  logic [31:0] instr,
  input  logic [31:0] regfile_r1,
  input  logic [31:0] cp0_pcout,
  input  logic        equal,
  input  logic        bneorbeq,
  input  logic        branch,
  input  logic        jump,
  input  logic        isjr,
  input  logic        iseret,
  input  logic        iscop0,
  input  logic        hasexp,
  output logic [31:0] next_pc,
  output logic [31:0] exc_pc
);

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        taken;

  assign pc4       = present_pc + 32'd4;
  assign br_target = pc4 + {extend_inst[29:0], 2'b00};
  assign j_target  = {pc4[31:28], instr[25:0], 2'b00};
  assign taken     = branch & ((~bneorbeq & equal) | (bneorbeq & ~equal));

  // Strict priority chain; only the selected source reaches the output.
  always_comb begin
    next_pc = pc4;
    if (!rst_n)                next_pc = RESET_VECTOR;
    else if (hasexp)           next_pc = cp0_pcout;
    else if (iseret && iscop0) next_pc = cp0_pcout;
    else if (isjr)             next_pc = regfile_r1;
    else if (jump)             next_pc = j_target;
    else if (taken)            next_pc = br_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      exc_pc <= 32'h0;
    else if (hasexp) exc_pc <= present_pc;
  end

endmodule

// File: tb/tb_mips_pc_next.sv
// Directed plus randomized checks of mips_pc_next against a behavioural
// next-PC model; the bench also plays the role of the datapath PC register.
module tb_mips_pc_next;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] present_pc, extend_inst, instr, regfile_r1, cp0_pcout;
  logic        equal, bneorbeq, branch, jump, isjr, iseret, iscop0, hasexp;
  logic [31:0] next_pc, exc_pc;

  logic [31:0] exc_model;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mips_pc_next #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .present_pc(present_pc), .extend_inst(extend_inst),
    .instr(instr), .regfile_r1(regfile_r1), .cp0_pcout(cp0_pcout), .equal(equal),
    .bneorbeq(bneorbeq), .branch(branch), .jump(jump), .isjr(isjr),
    .iseret(iseret), .iscop0(iscop0), .hasexp(hasexp),
    .next_pc(next_pc), .exc_pc(exc_pc)
  );

  // Reference: next PC from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] ref_next();
    longint unsigned seq, tgt;
    longint signed   off;
    seq = (longint'(present_pc) + 4) % 64'h1_0000_0000;
    if (!rst_n) return RV;
    if (hasexp) return cp0_pcout;
    if (iseret && iscop0) return cp0_pcout;
    if (isjr) return regfile_r1;
    if (jump) begin
      tgt = (seq / 64'h1000_0000) * 64'h1000_0000 + (longint'(instr) % 64'h400_0000) * 4;
      return tgt[31:0];
    end
    if (branch && (equal != bneorbeq)) begin
      off = longint'(signed'(extend_inst));
      tgt = longint'(seq) + off * 4;
      return tgt[31:0];
    end
    return seq[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_flags();
    equal = 0; bneorbeq = 0; branch = 0; jump = 0; isjr = 0;
    iseret = 0; iscop0 = 0; hasexp = 0;
    extend_inst = 0; instr = 0; regfile_r1 = 0; cp0_pcout = 0;
  endtask

  // One clock edge: check exc_pc capture, then load the PC register.
  task automatic tick();
    logic        h;
    logic [31:0] p, n;
    h = hasexp; p = present_pc; n = next_pc;
    @(posedge clk); #1;
    if (h) exc_model = p;
    check("exc_pc_edge", exc_pc, exc_model);
    present_pc = n;
    @(negedge clk);
  endtask

  initial begin
    clear_flags();
    present_pc = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    exc_model = 32'h0;
    check("reset_next_pc", next_pc, RV);
    check("reset_exc_pc", exc_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Sequential run from 0
    check("seq_pc0", present_pc, 32'h0);
    check("seq_next0", next_pc, 32'h4);
    tick();
    check("seq_pc1", present_pc, 32'h4);
    tick();
    check("seq_pc2", present_pc, 32'h8);

    // Jump, then branches
    jump = 1; instr = 32'h0800_000A; #1;
    check("jump", next_pc, 32'h28);
    clear_flags(); present_pc = 32'h28;
    branch = 1; equal = 1; extend_inst = 32'h4; #1;
    check("beq_taken", next_pc, 32'h3C);
    bneorbeq = 1; #1;
    check("bne_not_taken", next_pc, 32'h2C);
    bneorbeq = 0; extend_inst = 32'hFFFF_FFFF; #1;
    check("beq_neg_off", next_pc, 32'h28);

    // Exception
    clear_flags(); present_pc = 32'h3C;
    hasexp = 1; cp0_pcout = 32'h400; #1;
    check("exc_next", next_pc, 32'h400);
    tick();
    check("exc_pc_val", exc_pc, 32'h3C);
    present_pc = 32'h100;
    jump = 1; instr = 32'h0800_0040; isjr = 1; regfile_r1 = 32'h80;
    branch = 1; equal = 1; extend_inst = 32'h10; #1;
    check("exc_priority", next_pc, 32'h400);

    // ERET
    clear_flags(); present_pc = 32'h200;
    iseret = 1; iscop0 = 1; cp0_pcout = 32'h400; #1;
    check("eret", next_pc, 32'h400);
    iscop0 = 0; #1;
    check("eret_unqualified", next_pc, 32'h204);

    // JR over jump, then sequential
    clear_flags(); present_pc = 32'h300;
    isjr = 1; regfile_r1 = 32'h20; jump = 1; instr = 32'h0800_0100; #1;
    check("jr_priority", next_pc, 32'h20);
    tick();
    clear_flags(); #1;
    check("jr_land", present_pc, 32'h20);
    tick();
    check("jr_seq1", present_pc, 32'h24);
    tick();
    check("jr_seq2", present_pc, 32'h28);
    tick();
    check("jr_seq3", present_pc, 32'h2C);

    // Async reset mid-cycle
    rst_n = 1'b0; #1;
    exc_model = 32'h0;
    check("midrst_next", next_pc, RV);
    check("midrst_exc", exc_pc, 32'h0);
    rst_n = 1'b1; #1;
    check("rst_release", next_pc, 32'h30);

    // Wrap
    present_pc = 32'hFFFF_FFFC; #1;
    check("wrap", next_pc, 32'h0);

    // Randomized against the reference model
    for (int i = 0; i < 400; i++) begin
      present_pc  = {$urandom, 2'b00} >> 0;
      present_pc  = $urandom & 32'hFFFF_FFFC;
      extend_inst = ($urandom_range(0, 1) != 0) ? {{16{1'b1}}, 16'($urandom)} : {16'h0, 16'($urandom)};
      instr       = $urandom;
      regfile_r1  = $urandom;
      cp0_pcout   = $urandom;
      equal       = 1'($urandom);
      bneorbeq    = 1'($urandom);
      branch      = ($urandom_range(0, 2) == 0);
      jump        = ($urandom_range(0, 4) == 0);
      isjr        = ($urandom_range(0, 4) == 0);
      iseret      = ($urandom_range(0, 3) == 0);
      iscop0      = 1'($urandom);
      hasexp      = ($urandom_range(0, 6) == 0);
      #1;
      check("rand_next", next_pc, ref_next());
      if ($urandom_range(0, 31) == 0) begin
        rst_n = 1'b0; #1;
        exc_model = 32'h0;
        check("rand_rst_next", next_pc, ref_next());
        check("rand_rst_exc", exc_pc, 32'h0);
        rst_n = 1'b1; #1;
        check("rand_rst_release", next_pc, ref_next());
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
